// File: rtl/puf_eval_ctrl_if.sv
// rtl/puf_eval_ctrl_if.sv - challenge/response handshake and PUF drive bundle
interface puf_eval_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             chal_valid;
  logic             chal_ready;
  logic [WIDTH-1:0] chal_in;
  logic [WIDTH-1:0] puf_challenge;
  logic             puf_en;
  logic [WIDTH-1:0] puf_response;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_out;
  logic             resp_stable;

  // Side that supplies challenges, consumes responses and models the PUF.
  modport master (
    output chal_valid, chal_in, puf_response, resp_ready,
    input  chal_ready, puf_challenge, puf_en, resp_valid, resp_out, resp_stable
  );

  // The evaluation controller.
  modport slave (
    input  chal_valid, chal_in, puf_response, resp_ready,
    output chal_ready, puf_challenge, puf_en, resp_valid, resp_out, resp_stable
  );
endinterface

// File: rtl/puf_eval_ctrl.sv
// rtl/puf_eval_ctrl.sv - repeated PUF evaluation with per-bit majority vote
module puf_eval_ctrl #(
  parameter int WIDTH  = 16,
  parameter int REPEAT = 5,
  parameter int SETTLE = 4,
  parameter int GRAY   = 1
) (
  input  logic            clk,
  input  logic            rst,
  puf_eval_ctrl_if.slave  bus,
  output logic            busy
);
  localparam int CW = $clog2(REPEAT + 1);
  localparam int TW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {IDLE, SETUP, EVAL, RELAX, DONE} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CW-1:0]    iter_q, iter_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] chal_q, chal_d;
  logic [WIDTH-1:0] chal_enc;
  logic             puf_en_q, puf_en_d;
  logic [WIDTH-1:0] resp_out_q, resp_out_d;
  logic             resp_stable_q, resp_stable_d;

  // Optional Gray encoding: bit i = in[i]^in[i+1], MSB passes through.
  always_comb begin
    chal_enc = bus.chal_in;
    if (GRAY != 0) chal_enc = bus.chal_in ^ (bus.chal_in >> 1);
  end

  // Next-state, per-bit vote counters and result computation.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    iter_d        = iter_q;
    cnt_d         = cnt_q;
    chal_d        = chal_q;
    resp_out_d    = resp_out_q;
    resp_stable_d = resp_stable_q;
    case (state_q)
      IDLE: begin
        if (bus.chal_valid) begin
          state_d = SETUP;
          chal_d  = chal_enc;
          timer_d = '0;
          iter_d  = '0;
          for (int i = 0; i < WIDTH; i++) cnt_d[i] = '0;
        end
      end
      SETUP: begin
        state_d = EVAL;
        timer_d = '0;
      end
      EVAL: begin
        if (timer_q == TW'(SETTLE - 1)) begin
          // Sample on the edge that leaves EVAL, while the PUF is still enabled.
          state_d = RELAX;
          timer_d = '0;
          iter_d  = iter_q + 1'b1;
          for (int i = 0; i < WIDTH; i++) cnt_d[i] = cnt_q[i] + CW'(bus.puf_response[i]);
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RELAX: begin
        if (timer_q == TW'(SETTLE - 1)) begin
          timer_d = '0;
          if (iter_q < CW'(REPEAT)) begin
            state_d = EVAL;
          end else begin
            state_d       = DONE;
            resp_stable_d = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
              resp_out_d[i] = (cnt_q[i] > CW'(REPEAT / 2));
              if (!((cnt_q[i] == '0) || (cnt_q[i] == CW'(REPEAT)))) resp_stable_d = 1'b0;
            end
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The PUF is only ever enabled while in EVAL.
    puf_en_d = (state_d == EVAL);
  end

  // State and datapath registers; reset discards any partial evaluation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      iter_q        <= '0;
      chal_q        <= '0;
      puf_en_q      <= 1'b0;
      resp_out_q    <= '0;
      resp_stable_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      iter_q        <= iter_d;
      chal_q        <= chal_d;
      puf_en_q      <= puf_en_d;
      resp_out_q    <= resp_out_d;
      resp_stable_q <= resp_stable_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.chal_ready    = (state_q == IDLE) && !rst;
  assign bus.resp_valid    = (state_q == DONE);
  assign bus.puf_challenge = chal_q;
  assign bus.puf_en        = puf_en_q;
  assign bus.resp_out      = resp_out_q;
  assign bus.resp_stable   = resp_stable_q;
  assign busy              = (state_q != IDLE);
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb/tb_puf_eval_ctrl.sv - directed bench for puf_eval_ctrl
module tb_puf_eval_ctrl;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic busy_a, busy_b;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] samp [5];

  always #5 clk = ~clk;

  puf_eval_ctrl_if #(.WIDTH(16)) ifa ();
  puf_eval_ctrl_if #(.WIDTH(16)) ifb ();

  puf_eval_ctrl #(.WIDTH(16), .REPEAT(5), .SETTLE(4), .GRAY(1)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa.slave), .busy(busy_a)
  );

  puf_eval_ctrl #(.WIDTH(16), .REPEAT(1), .SETTLE(1), .GRAY(0)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb.slave), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one challenge to dut_a and follow it to edge 41 using samples in samp[].
  task automatic run_a(input string tag, input logic [15:0] chal, input logic [15:0] exp_ch,
                       input logic [15:0] exp_out, input logic exp_st);
    int bad_en = 0;
    int bad_v  = 0;
    logic exp_en;
    @(negedge clk);
    ifa.chal_valid = 1'b1;
    ifa.chal_in    = chal;
    @(posedge clk); #1;
    ifa.chal_valid = 1'b0;
    chk({tag, "_chal"}, 32'(ifa.puf_challenge), 32'(exp_ch));
    chk({tag, "_busy"}, 32'(busy_a), 32'd1);
    for (int e = 1; e <= 41; e++) begin
      if (e <= 40) ifa.puf_response = samp[(e - 1) / 8];
      @(posedge clk); #1;
      exp_en = (e <= 40) && (((e - 1) % 8) < 4);
      if (ifa.puf_en !== exp_en) bad_en++;
      if (e < 41 && ifa.resp_valid !== 1'b0) bad_v++;
    end
    chk({tag, "_en_pattern_errs"}, 32'(bad_en), 32'd0);
    chk({tag, "_early_valid_errs"}, 32'(bad_v), 32'd0);
    chk({tag, "_valid41"}, 32'(ifa.resp_valid), 32'd1);
    chk({tag, "_resp_out"}, 32'(ifa.resp_out), 32'(exp_out));
    chk({tag, "_stable"}, 32'(ifa.resp_stable), 32'(exp_st));
  endtask

  task automatic hs_a(input string tag);
    ifa.resp_ready = 1'b1;
    @(posedge clk); #1;
    ifa.resp_ready = 1'b0;
    chk({tag, "_hs_valid"}, 32'(ifa.resp_valid), 32'd0);
    chk({tag, "_hs_ready"}, 32'(ifa.chal_ready), 32'd1);
  endtask

  initial begin
    int bad;
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.chal_valid = 1'b0; ifa.chal_in = '0; ifa.puf_response = '0; ifa.resp_ready = 1'b0;
    ifb.chal_valid = 1'b0; ifb.chal_in = '0; ifb.puf_response = '0; ifb.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_chal_ready_low", 32'(ifa.chal_ready), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    chk("rst_chal_ready", 32'(ifa.chal_ready), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_puf_en", 32'(ifa.puf_en), 32'd0);
    chk("rst_resp_valid", 32'(ifa.resp_valid), 32'd0);
    chk("rst_resp_out", 32'(ifa.resp_out), 32'd0);
    chk("rst_puf_chal", 32'(ifa.puf_challenge), 32'd0);

    // Constant response, Gray-encoded challenge 0x0003 -> 0x0002.
    samp = '{16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5};
    run_a("const", 16'h0003, 16'h0002, 16'hA5A5, 1'b1);
    hs_a("const");

    // Majority: bit0 = 1,1,0,1,0 -> 1, unstable.
    samp = '{16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h0000};
    run_a("maj3", 16'h00F0, 16'h0088, 16'h0001, 1'b0);
    hs_a("maj3");

    // Majority: bit0 = 1,0,0,1,0 -> 0, unstable.
    samp = '{16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'h0000};
    run_a("maj2", 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
    hs_a("maj2");

    // Backpressure with a competing challenge pulsed on the input.
    samp = '{16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F};
    run_a("bp", 16'h5555, 16'h7FFF, 16'h0F0F, 1'b1);
    bad = 0;
    ifa.chal_in = 16'h1234;
    for (int c = 0; c < 10; c++) begin
      ifa.chal_valid = (c % 2 == 0);
      @(posedge clk); #1;
      if (ifa.resp_valid !== 1'b1 || ifa.resp_out !== 16'h0F0F || ifa.resp_stable !== 1'b1 ||
          ifa.chal_ready !== 1'b0 || ifa.puf_challenge !== 16'h7FFF) bad++;
    end
    chk("bp_frozen_errs", 32'(bad), 32'd0);
    ifa.chal_valid = 1'b1;
    ifa.resp_ready = 1'b1;
    @(posedge clk); #1;
    ifa.resp_ready = 1'b0;
    chk("bp_hs_valid", 32'(ifa.resp_valid), 32'd0);
    chk("bp_hs_ready", 32'(ifa.chal_ready), 32'd1);
    chk("bp_not_taken", 32'(ifa.puf_challenge), 32'h7FFF);
    @(posedge clk); #1;
    ifa.chal_valid = 1'b0;
    chk("bp_taken_busy", 32'(busy_a), 32'd1);
    chk("bp_taken_chal", 32'(ifa.puf_challenge), 32'h1B2E);

    // Abort during the fourth evaluation (edges 25..28).
    ifa.puf_response = 16'hFFFF;
    repeat (26) @(posedge clk);
    #1;
    chk("abort_pre_en", 32'(ifa.puf_en), 32'd1);
    #2;
    rst_a = 1'b1;
    #1;
    chk("abort_puf_en", 32'(ifa.puf_en), 32'd0);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_valid", 32'(ifa.resp_valid), 32'd0);
    chk("abort_resp_out", 32'(ifa.resp_out), 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    chk("abort_ready", 32'(ifa.chal_ready), 32'd1);
    samp = '{16'h0001, 16'h8001, 16'h8000, 16'h0001, 16'h8000};
    run_a("post", 16'h00FF, 16'h0080, 16'h8001, 1'b0);
    hs_a("post");

    // Minimal configuration: no Gray, single evaluation, one-cycle settle.
    @(negedge clk);
    ifb.chal_valid = 1'b1;
    ifb.chal_in    = 16'h8001;
    @(posedge clk); #1;
    ifb.chal_valid   = 1'b0;
    ifb.puf_response = 16'h3C5A;
    chk("b_chal", 32'(ifb.puf_challenge), 32'h8001);
    @(posedge clk); #1;
    chk("b_e1_en", 32'(ifb.puf_en), 32'd1);
    chk("b_e1_valid", 32'(ifb.resp_valid), 32'd0);
    @(posedge clk); #1;
    ifb.puf_response = 16'h0000;
    chk("b_e2_en", 32'(ifb.puf_en), 32'd0);
    chk("b_e2_valid", 32'(ifb.resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("b_e3_valid", 32'(ifb.resp_valid), 32'd1);
    chk("b_resp_out", 32'(ifb.resp_out), 32'h3C5A);
    chk("b_stable", 32'(ifb.resp_stable), 32'd1);
    ifb.resp_ready = 1'b1;
    @(posedge clk); #1;
    ifb.resp_ready = 1'b0;
    chk("b_hs_ready", 32'(ifb.chal_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
